// File: rtl/icache_pkg.sv
// icache_pkg: shared types, defaults and FSM encodings for the instruction cache
package icache_pkg;
    typedef logic [31:0] ADDR_TP;
    typedef logic [31:0] WORD_TP;
    localparam ADDR_TP ZERO_ADDR = '0;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_SETS = 64;
    typedef enum logic {IC_IDLE, IC_REFILL} ic_state_e;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch lookup (cache_rd_*, cache_hit*) and memory refill (mem_rd_*) signals; slave = cache, master = fetch/memory side
interface icache_if;
    import icache_pkg::*;
    logic   cache_rd_en;
    ADDR_TP cache_rd_addr;
    logic   cache_hit;
    WORD_TP cache_hit_inst;
    logic   mem_rd_en;
    ADDR_TP mem_rd_addr;
    logic   mem_rd_done;
    WORD_TP mem_rd_data;
    modport slave (
        input  cache_rd_en, cache_rd_addr, mem_rd_done, mem_rd_data,
        output cache_hit, cache_hit_inst, mem_rd_en, mem_rd_addr
    );
    modport master (
        output cache_rd_en, cache_rd_addr, mem_rd_done, mem_rd_data,
        input  cache_hit, cache_hit_inst, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage; async read by rd_idx/rd_off, sync word write and tag set / valid clear at w_idx
module icache_array
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int SETS = ICACHE_SETS,
    localparam int OFF_W = $clog2(LINE_WORDS),
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output WORD_TP           rd_data,
    input  logic [IDX_W-1:0] w_idx,
    input  logic             wr_en,
    input  logic [OFF_W-1:0] wr_off,
    input  WORD_TP           wr_data,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_en
);
    logic [SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem [SETS];
    WORD_TP data_mem [SETS][LINE_WORDS];
    always_comb begin
        valid_d = valid_q;
        if (clr_en) valid_d[w_idx] = FALSE;
        if (set_en) valid_d[w_idx] = TRUE;
    end
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else valid_q <= valid_d;
    end
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[w_idx][wr_off] <= wr_data;
        if (set_en) tag_mem[w_idx] <= set_tag;
    end
    assign rd_valid = valid_q[rd_idx];
    assign rd_tag = tag_mem[rd_idx];
    assign rd_data = data_mem[rd_idx][rd_off];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only icache; clk/rst/rdy plus bus (icache_if.slave) carrying combinational lookup and line refill
module icache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int SETS = ICACHE_SETS
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    icache_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
    ic_state_e state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    ADDR_TP addr_q, addr_d;
    logic wr_en, set_en, clr_en, rd_valid;
    logic [TAG_W-1:0] rd_tag;
    WORD_TP rd_data;
    wire [TAG_W-1:0] req_tag = bus.cache_rd_addr[31:32-TAG_W];
    wire [IDX_W-1:0] req_idx = bus.cache_rd_addr[IDX_W+OFF_W+1:OFF_W+2];
    wire [OFF_W-1:0] req_off = bus.cache_rd_addr[OFF_W+1:2];
    wire [TAG_W-1:0] fill_tag = addr_q[31:32-TAG_W];
    wire [IDX_W-1:0] fill_idx = addr_q[IDX_W+OFF_W+1:OFF_W+2];
    icache_array #(.LINE_WORDS(LINE_WORDS), .SETS(SETS)) u_array (
        .clk(clk),
        .rst(rst),
        .rd_idx(req_idx),
        .rd_off(req_off),
        .rd_valid(rd_valid),
        .rd_tag(rd_tag),
        .rd_data(rd_data),
        .w_idx(state_q == IC_IDLE ? req_idx : fill_idx),
        .wr_en(wr_en),
        .wr_off(cnt_q),
        .wr_data(bus.mem_rd_data),
        .set_en(set_en),
        .set_tag(fill_tag),
        .clr_en(clr_en)
    );
    assign bus.cache_hit = bus.cache_rd_en & rd_valid & (rd_tag == req_tag);
    assign bus.cache_hit_inst = bus.cache_hit ? rd_data : '0;
    assign bus.mem_rd_en = state_q == IC_REFILL;
    assign bus.mem_rd_addr = addr_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        clr_en = FALSE;
        wr_en = FALSE;
        set_en = FALSE;
        if (rdy && state_q == IC_IDLE && bus.cache_rd_en && !bus.cache_hit) begin
            state_d = IC_REFILL;
            cnt_d = '0;
            addr_d = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
            clr_en = TRUE;
        end
        if (rdy && state_q == IC_REFILL && bus.mem_rd_done) begin
            wr_en = TRUE;
            cnt_d = cnt_q + 1'b1;
            addr_d = addr_q + 32'd4;
            set_en = &cnt_q;
            state_d = &cnt_q ? IC_IDLE : IC_REFILL;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IC_IDLE;
            cnt_q <= '0;
            addr_q <= ZERO_ADDR;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
        end
    end
endmodule
